add_op_sequencer: RTL and testbench
===================================

Name: add_op_sequencer

Overview:
- Control stage directly upstream of the 4-bit adder datapath.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Issues each pair to the datapath by holding start and the operands until done, then returns the 4-bit sum to a consumer over valid/ready.
- Adds a done timeout with datapath abort, a result self-check, and a result counter.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles in WAIT without dp_done before abort (>=2)

Ports:
clka  input  1  single clock, rising-edge
restart_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept (= not full)
in_a  input  4  operand A
in_b  input  4  operand B
dp_start  output  1  start to datapath, held through WAIT
dp_restart  output  1  restart to datapath
dp_d1  output  4  operand A to datapath
dp_d2  output  4  operand B to datapath
dp_done  input  1  datapath done
dp_dout  input  4  datapath result
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
res_sum  output  4  captured result
chk_err  output  1  sticky: captured result != (A+B) mod 16
tmo_err  output  1  sticky: a timeout abort occurred
op_count  output  8  accepted-result counter

Behaviour:
- Reset (restart_n low, async): FSM=IDLE, FIFO empty, in_ready=0, dp_start=0, dp_restart=1, dp_d1/dp_d2=0, res_valid=0, res_sum=0, chk_err=0, tmo_err=0, op_count=0, timer=0.
- First rising clka after release: dp_restart drops to 0; in_ready = !full from that edge on.
- All outputs registered. Only in_ready is combinational (!full), and it is forced 0 during reset.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Full: in_ready=0; in_valid is ignored and the data is not stored.
  - Pointers wrap modulo DEPTH.
- IDLE: go to ISSUE when FIFO non-empty && dp_done==0. A stale done blocks issue. On the transition, load op_a/op_b from the FIFO head into dp_d1/dp_d2.
- ISSUE (1 cycle): dp_start=1; timer cleared; go to WAIT.
- WAIT:
  - dp_start=1; dp_d1/dp_d2 held stable; timer increments each cycle.
  - If dp_done==1: res_sum<=dp_dout, res_valid<=1, dp_start<=0, go to HOLD. If dp_dout != (op_a+op_b)[3:0], set chk_err.
  - Else if timer==TIMEOUT-1: go to ABORT, dp_start<=0.
  - dp_done and timeout in the same cycle: done wins.
- HOLD:
  - res_valid=1 with res_sum stable until res_ready.
  - On res_valid && res_ready: res_valid<=0, op_count<=op_count+1 (wraps 255->0), go to IDLE.
  - res_ready is ignored when res_valid=0.
- ABORT (1 cycle): dp_restart=1, tmo_err<=1, no result is produced, op_count unchanged, go to IDLE. The aborted operand pair is dropped.
- chk_err and tmo_err clear only on reset.
- Reset mid-operation: everything returns to reset values immediately; buffered operands are lost; dp_restart=1 restarts the datapath.
- Minimum issue-to-result latency: ISSUE + 1 WAIT cycle, so res_valid rises 2 cycles after the pop when done is already high. Max throughput: one pair per 4 cycles.
- Arithmetic: the check sum is 4-bit mod 16; carry is discarded, matching the datapath.

Test Plan:
- Reset then push (3,4) with res_ready=1; model dp done after 2 cycles with dout=7 -> dp_start high ISSUE..WAIT, res_sum=7, res_valid 1 cycle, op_count=1, chk_err=0.
- Push (9,8) with dp model returning 1 -> res_sum=1 (wrap), chk_err=0. Next pair (2,2) with model returning 5 -> res_sum=5, chk_err=1 and it stays set.
- Hold res_ready=0, push 5 pairs back-to-back with DEPTH=4 -> in_ready=0 after FIFO full; 5th pair accepted only after a pop. res_sum holds until res_ready=1. All results appear in push order.
- dp model never asserts done -> after TIMEOUT=16 WAIT cycles, dp_restart pulses 1 cycle, tmo_err=1, no res_valid, op_count unchanged, next queued pair issues normally.
- dp_done still high from the previous op while a pair is queued -> no ISSUE until dp_done=0. Done and timeout on the same cycle -> result captured, tmo_err stays 0.
- Assert restart_n low in WAIT with 3 pairs queued -> all outputs at reset values asynchronously, dp_restart=1, FIFO empty after release, op_count=0.

Source files
------------

// File: rtl/add_op_sequencer.sv
// Sequencer in front of the 4-bit adder datapath. It buffers operand pairs, issues one
// at a time with a done timeout, checks each result and hands it to a consumer.
module add_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       clka,
   input  logic       restart_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic       dp_start,
   output logic       dp_restart,
   output logic [3:0] dp_d1,
   output logic [3:0] dp_d2,
   input  logic       dp_done,
   input  logic [3:0] dp_dout,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_sum,
   output logic       chk_err,
   output logic       tmo_err,
   output logic [7:0] op_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, ABORT} state_t;

   state_t        state;
   state_t        next_state;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    head;
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [TW-1:0] timer;
   logic          alive;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [3:0]    exp_sum;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = alive && !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && (next_state == ISSUE);
   assign head     = mem[rd_ptr[PW-1:0]];
   assign exp_sum  = dp_d1 + dp_d2;

   always_ff @(posedge clka) begin
      if (push) begin
         mem[wr_ptr[PW-1:0]] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A done still high from the previous operation must not start a new one.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!empty && !dp_done) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT: begin
            if (dp_done) begin
               next_state = HOLD;
            end else if (timer == TMO_LAST) begin
               next_state = ABORT;
            end
         end
         HOLD:    if (res_valid && res_ready) next_state = IDLE;
         ABORT:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         alive      <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         timer      <= '0;
         dp_start   <= 1'b0;
         dp_restart <= 1'b1;
         dp_d1      <= 4'd0;
         dp_d2      <= 4'd0;
         res_valid  <= 1'b0;
         res_sum    <= 4'd0;
         chk_err    <= 1'b0;
         tmo_err    <= 1'b0;
         op_count   <= 8'd0;
      end else begin
         alive      <= 1'b1;
         dp_start   <= (next_state == ISSUE) || (next_state == WAIT);
         dp_restart <= (next_state == ABORT);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dp_d1  <= head[7:4];
            dp_d2  <= head[3:0];
         end
         if (state == ISSUE) begin
            timer <= '0;
         end else if (state == WAIT) begin
            timer <= timer + TMR_ONE;
         end
         if ((state == WAIT) && dp_done) begin
            res_sum   <= dp_dout;
            res_valid <= 1'b1;
            if (dp_dout != exp_sum) begin
               chk_err <= 1'b1;
            end
         end
         if ((state == HOLD) && res_valid && res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
         end
         if (next_state == ABORT) begin
            tmo_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_op_sequencer.sv
// Directed self-checking bench for add_op_sequencer; the bench drives the datapath
// side itself with hand-chosen done timing and results.
module tb_add_op_sequencer;

   logic       clka;
   logic       restart_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       dp_start;
   logic       dp_restart;
   logic [3:0] dp_d1;
   logic [3:0] dp_d2;
   logic       dp_done;
   logic [3:0] dp_dout;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_sum;
   logic       chk_err;
   logic       tmo_err;
   logic [7:0] op_count;

   int checks   = 0;
   int failures = 0;

   logic [3:0] pa [5];
   logic [3:0] pb [5];
   logic [3:0] ps [5];

   add_op_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clka       (clka),
      .restart_n  (restart_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .dp_start   (dp_start),
      .dp_restart (dp_restart),
      .dp_d1      (dp_d1),
      .dp_d2      (dp_d2),
      .dp_done    (dp_done),
      .dp_dout    (dp_dout),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .chk_err    (chk_err),
      .tmo_err    (tmo_err),
      .op_count   (op_count)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (dp_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_output("start_seen", 32'(dp_start), 1);
   endtask

   // Issue the queued head, answer done in the first WAIT cycle with dout, then accept it.
   task automatic serve_one(input logic [3:0] a, input logic [3:0] b, input logic [3:0] dout);
      wait_start();
      check_output("issue_d1", 32'(dp_d1), 32'(a));
      check_output("issue_d2", 32'(dp_d2), 32'(b));
      tick();
      check_output("start_held", 32'(dp_start), 1);
      check_output("no_early_valid", 32'(res_valid), 0);
      dp_done = 1'b1;
      dp_dout = dout;
      tick();
      dp_done = 1'b0;
      check_output("res_valid_up", 32'(res_valid), 1);
      check_output("res_sum", 32'(res_sum), 32'(dout));
      check_output("start_dropped", 32'(dp_start), 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_output("res_valid_down", 32'(res_valid), 0);
   endtask

   initial begin
      pa = '{4'd1, 4'd4, 4'd7, 4'd15, 4'd6};
      pb = '{4'd2, 4'd5, 4'd7, 4'd3,  4'd9};
      ps = '{4'd3, 4'd9, 4'd14, 4'd2, 4'd15};
      in_valid  = 1'b0;
      in_a      = 4'd0;
      in_b      = 4'd0;
      dp_done   = 1'b0;
      dp_dout   = 4'd0;
      res_ready = 1'b0;
      restart_n = 1'b1;

      #2 restart_n = 1'b0;
      #1;
      check_output("rst_in_ready", 32'(in_ready), 0);
      check_output("rst_dp_start", 32'(dp_start), 0);
      check_output("rst_dp_restart", 32'(dp_restart), 1);
      check_output("rst_dp_d1", 32'(dp_d1), 0);
      check_output("rst_res_valid", 32'(res_valid), 0);
      check_output("rst_res_sum", 32'(res_sum), 0);
      check_output("rst_chk_err", 32'(chk_err), 0);
      check_output("rst_tmo_err", 32'(tmo_err), 0);
      check_output("rst_op_count", 32'(op_count), 0);

      #19 restart_n = 1'b1;
      #1;
      check_output("release_restart_held", 32'(dp_restart), 1);
      check_output("release_in_ready_low", 32'(in_ready), 0);
      tick();
      check_output("first_edge_restart", 32'(dp_restart), 0);
      check_output("first_edge_in_ready", 32'(in_ready), 1);

      $display("[TB] basic operations");
      push(4'd3, 4'd4);
      serve_one(4'd3, 4'd4, 4'd7);
      check_output("count_1", 32'(op_count), 1);
      check_output("chk_clean_1", 32'(chk_err), 0);
      push(4'd9, 4'd8);
      serve_one(4'd9, 4'd8, 4'd1);
      check_output("count_2", 32'(op_count), 2);
      check_output("chk_clean_wrap", 32'(chk_err), 0);
      push(4'd2, 4'd2);
      serve_one(4'd2, 4'd2, 4'd5);
      check_output("chk_set", 32'(chk_err), 1);
      check_output("count_3", 32'(op_count), 3);

      $display("[TB] done coincides with timeout");
      push(4'd8, 4'd8);
      wait_start();
      check_output("coinc_d1", 32'(dp_d1), 8);
      tick();
      repeat (15) tick();
      check_output("coinc_still_wait", 32'(dp_start), 1);
      check_output("coinc_no_restart", 32'(dp_restart), 0);
      dp_done = 1'b1;
      dp_dout = 4'd0;
      tick();
      dp_done = 1'b0;
      check_output("coinc_valid", 32'(res_valid), 1);
      check_output("coinc_sum", 32'(res_sum), 0);
      check_output("coinc_tmo_clear", 32'(tmo_err), 0);
      check_output("coinc_restart_low", 32'(dp_restart), 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_output("count_4", 32'(op_count), 4);

      $display("[TB] fill FIFO behind a stale done");
      dp_done = 1'b1;
      dp_dout = 4'hF;
      for (int k = 0; k < 4; k++) begin
         check_output("fill_ready", 32'(in_ready), 1);
         push(pa[k], pb[k]);
      end
      check_output("full_ready_low", 32'(in_ready), 0);
      check_output("stale_done_blocks", 32'(dp_start), 0);
      in_valid = 1'b1;
      in_a     = pa[4];
      in_b     = pb[4];
      tick();
      tick();
      check_output("full_still_low", 32'(in_ready), 0);
      check_output("stale_still_blocks", 32'(dp_start), 0);
      dp_done = 1'b0;
      tick();
      check_output("ready_after_pop", 32'(in_ready), 1);
      check_output("issue_after_stale", 32'(dp_start), 1);
      tick();
      in_valid = 1'b0;
      check_output("full_again", 32'(in_ready), 0);
      check_output("p1_d1", 32'(dp_d1), 32'(pa[0]));
      check_output("p1_d2", 32'(dp_d2), 32'(pb[0]));
      dp_done = 1'b1;
      dp_dout = ps[0];
      tick();
      dp_done = 1'b0;
      check_output("p1_valid", 32'(res_valid), 1);
      repeat (3) tick();
      check_output("p1_valid_held", 32'(res_valid), 1);
      check_output("p1_sum_held", 32'(res_sum), 32'(ps[0]));
      check_output("p1_count_held", 32'(op_count), 4);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_output("count_5", 32'(op_count), 5);
      check_output("p1_valid_down", 32'(res_valid), 0);
      for (int k = 1; k < 5; k++) begin
         serve_one(pa[k], pb[k], ps[k]);
      end
      check_output("count_9", 32'(op_count), 9);
      check_output("chk_sticky", 32'(chk_err), 1);

      $display("[TB] done timeout");
      push(4'd5, 4'd5);
      push(4'd3, 4'd3);
      check_output("tmo_issue", 32'(dp_start), 1);
      check_output("tmo_d1", 32'(dp_d1), 5);
      tick();
      repeat (15) tick();
      check_output("tmo_last_wait", 32'(dp_start), 1);
      check_output("tmo_not_yet", 32'(tmo_err), 0);
      check_output("tmo_no_restart_yet", 32'(dp_restart), 0);
      tick();
      check_output("abort_restart", 32'(dp_restart), 1);
      check_output("abort_start_low", 32'(dp_start), 0);
      check_output("abort_no_valid", 32'(res_valid), 0);
      tick();
      check_output("abort_restart_pulse", 32'(dp_restart), 0);
      check_output("tmo_set", 32'(tmo_err), 1);
      check_output("abort_count_same", 32'(op_count), 9);
      check_output("abort_still_no_valid", 32'(res_valid), 0);
      serve_one(4'd3, 4'd3, 4'd6);
      check_output("count_10", 32'(op_count), 10);
      check_output("tmo_sticky", 32'(tmo_err), 1);

      $display("[TB] reset during WAIT with pairs queued");
      push(4'd1, 4'd1);
      push(4'd2, 4'd2);
      push(4'd3, 4'd3);
      push(4'd4, 4'd4);
      check_output("pre_reset_wait", 32'(dp_start), 1);
      #3 restart_n = 1'b0;
      #1;
      check_output("mid_rst_start", 32'(dp_start), 0);
      check_output("mid_rst_restart", 32'(dp_restart), 1);
      check_output("mid_rst_in_ready", 32'(in_ready), 0);
      check_output("mid_rst_d1", 32'(dp_d1), 0);
      check_output("mid_rst_count", 32'(op_count), 0);
      check_output("mid_rst_chk", 32'(chk_err), 0);
      check_output("mid_rst_tmo", 32'(tmo_err), 0);
      #2 restart_n = 1'b1;
      tick();
      check_output("post_rst_restart", 32'(dp_restart), 0);
      check_output("post_rst_ready", 32'(in_ready), 1);
      repeat (4) tick();
      check_output("post_rst_fifo_empty", 32'(dp_start), 0);
      check_output("post_rst_count", 32'(op_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
